// File: rtl/decision_tx_arbiter.sv
// Round-robin arbiter sharing one valid/ready TX output among NUM_REQ
// sources, each with a one-entry holding slot and saturating statistics.
module decision_tx_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 32,
    parameter  int TYPE_W  = 8,
    parameter  int CNT_W   = 16,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*TYPE_W-1:0] req_type,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TYPE_W-1:0]         out_type,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic [CNT_W-1:0]          sent_cnt,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state, state_nxt;
    logic [NUM_REQ-1:0]   slot_full;
    logic [TYPE_W-1:0]    slot_type [NUM_REQ];
    logic [DATA_W-1:0]    slot_data [NUM_REQ];
    logic [SRC_W-1:0]     ptr;
    logic [SRC_W-1:0]     gnt;
    logic                 gnt_found;
    logic                 load_en;
    int                   idx;

    assign out_valid = (state == SEND);
    assign req_ready = ~slot_full & {NUM_REQ{~flush}};
    assign load_en   = (!out_valid || out_ready) && (|slot_full) && !flush;

    // Pick the first full slot after the last granted index, wrapping around.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!gnt_found && slot_full[idx]) begin
                gnt_found = 1'b1;
                gnt       = SRC_W'(idx);
            end
        end
    end

    // Next-state logic: state tracks whether the output register holds a decision.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (load_en) state_nxt = SEND;
            SEND: begin
                if (flush) state_nxt = IDLE;
                else if (out_ready && !load_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Holding slots: capture on handshake, release on grant, wipe on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_type[i] <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    slot_full[i] <= 1'b0;
                end else if (load_en && gnt == SRC_W'(i)) begin
                    slot_full[i] <= 1'b0;
                end else if (req_valid[i] && req_ready[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_type[i] <= req_type[i*TYPE_W +: TYPE_W];
                    slot_data[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Output register and round-robin pointer update on each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_type <= '0;
            out_data <= '0;
            out_src  <= '0;
            ptr      <= SRC_W'(NUM_REQ - 1);
        end else if (load_en) begin
            out_type <= slot_type[gnt];
            out_data <= slot_data[gnt];
            out_src  <= gnt;
            ptr      <= gnt;
        end
    end

    // Saturating handshake and stall counters; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready && sent_cnt != CNT_MAX)
                sent_cnt <= sent_cnt + 1'b1;
            if (out_valid && !out_ready && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_decision_tx_arbiter.sv
// Bench for decision_tx_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural slot/queue model.
module tb_decision_tx_arbiter;

    localparam int N  = 4;
    localparam int TW = 8;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int SW = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 0;
    logic            rst_n = 0;
    logic            flush = 0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_type = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            out_valid;
    logic            out_ready = 0;
    logic [TW-1:0]   out_type;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;
    logic [CW-1:0]   sent_cnt;
    logic [CW-1:0]   stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    // model state
    bit        m_full [N];
    bit [7:0]  m_type [N];
    bit [31:0] m_data [N];
    int        m_ptr;
    bit        m_valid;
    int        m_src;
    bit [7:0]  m_otype;
    bit [31:0] m_odata;
    int        m_sent;
    int        m_stall;

    decision_tx_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .TYPE_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_data(req_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_data(out_data), .out_src(out_src),
        .sent_cnt(sent_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0; m_type[i] = 0; m_data[i] = 0;
        end
        m_ptr = N - 1; m_valid = 0; m_src = 0;
        m_otype = 0; m_odata = 0; m_sent = 0; m_stall = 0;
    endtask

    // Compute next model state from the inputs currently applied.
    task automatic model_next();
        bit nfull [N];
        bit any;
        bit load;
        bit found;
        int g;
        any = 0;
        for (int i = 0; i < N; i++) begin
            nfull[i] = m_full[i];
            any |= m_full[i];
        end
        load = (!m_valid || out_ready) && any && !flush;
        if (m_valid && out_ready) m_sent = (m_sent < CMAX) ? m_sent + 1 : CMAX;
        if (m_valid && !out_ready) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (load) begin
            found = 0; g = 0;
            for (int k = 1; k <= N; k++)
                if (!found && m_full[(m_ptr + k) % N]) begin
                    found = 1; g = (m_ptr + k) % N;
                end
            m_src = g; m_otype = m_type[g]; m_odata = m_data[g];
            m_valid = 1; nfull[g] = 0; m_ptr = g;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (flush) begin
            m_valid = 0;
            for (int i = 0; i < N; i++) nfull[i] = 0;
        end else begin
            for (int i = 0; i < N; i++)
                if (req_valid[i] && !m_full[i]) begin
                    nfull[i] = 1;
                    m_type[i] = req_type[i*TW +: TW];
                    m_data[i] = req_data[i*DW +: DW];
                end
        end
        for (int i = 0; i < N; i++) m_full[i] = nfull[i];
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] rdy;
        for (int i = 0; i < N; i++) rdy[i] = !m_full[i] && !flush;
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".src"},   64'(out_src),   64'(m_src));
        chk({tag, ".type"},  64'(out_type),  64'(m_otype));
        chk({tag, ".data"},  64'(out_data),  64'(m_odata));
        chk({tag, ".sent"},  64'(sent_cnt),  64'(m_sent));
        chk({tag, ".stall"}, 64'(stall_cnt), 64'(m_stall));
        chk({tag, ".ready"}, 64'(req_ready), 64'(rdy));
    endtask

    // One clock: apply inputs, step model, then check after the edge.
    task automatic step(input string tag, input logic [N-1:0] v,
                        input logic ordy, input logic fl, input bit rnd);
        req_valid = v; out_ready = ordy; flush = fl;
        if (rnd) begin
            req_type = $urandom;
            req_data = {$urandom, $urandom, $urandom, $urandom};
        end
        #1;
        model_next();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 0; req_valid = '0; flush = 0; out_ready = 0;
        model_reset();
        @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
        check_all("reset");
    endtask

    initial begin
        // Reset then single request from requester 2
        do_reset();
        req_type = '0; req_data = '0;
        req_type[23:16] = 8'h42;
        req_data[95:64] = 32'hDEADBEEF;
        step("single.hs", 4'b0100, 1, 0, 0);
        chk("single.noval", 64'(out_valid), 64'd0);
        step("single.load", 4'b0000, 1, 0, 1);
        chk("single.v", 64'(out_valid), 64'd1);
        chk("single.src", 64'(out_src), 64'd2);
        chk("single.data", 64'(out_data), 64'hDEADBEEF);
        chk("single.type", 64'(out_type), 64'h42);
        step("single.done", 4'b0000, 1, 0, 1);
        chk("single.sent", 64'(sent_cnt), 64'd1);

        // All four slots loaded together, drained in order 0..3
        do_reset();
        step("all.hs", 4'b1111, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step("all.drain", 4'b0000, 1, 0, 1);
            chk("all.src", 64'(out_src), 64'(i));
        end
        step("all.end", 4'b0000, 1, 0, 1);
        chk("all.sent", 64'(sent_cnt), 64'd4);
        chk("all.ready", 64'(req_ready), 64'hF);

        // Back-pressure for 10 cycles then release
        do_reset();
        step("bp.hs", 4'b0010, 0, 0, 1);
        step("bp.load", 4'b0000, 0, 0, 1);
        for (int i = 0; i < 10; i++) step("bp.hold", 4'b0000, 0, 0, 1);
        chk("bp.stall", 64'(stall_cnt), 64'd10);
        chk("bp.src", 64'(out_src), 64'd1);
        step("bp.rel", 4'b0000, 1, 0, 1);
        chk("bp.sent", 64'(sent_cnt), 64'd1);

        // Fairness between requesters 0 and 3 (sent_cnt saturates at 15)
        do_reset();
        for (int i = 0; i < 24; i++) step("fair", 4'b1001, 1, 0, 1);
        step("fair.end", 4'b0000, 1, 0, 1);
        chk("fair.sat", 64'(sent_cnt), 64'(CMAX));

        // Flush with slots 1 and 3 full and an output stalled
        do_reset();
        step("fl.hs", 4'b1011, 0, 0, 1);
        step("fl.load", 4'b0000, 0, 0, 1);
        chk("fl.pre.v", 64'(out_valid), 64'd1);
        step("fl.flush", 4'b0100, 0, 1, 1);
        chk("fl.v", 64'(out_valid), 64'd0);
        chk("fl.stall", 64'(stall_cnt), 64'd1);
        step("fl.after", 4'b0000, 1, 0, 1);
        chk("fl.rdy", 64'(req_ready), 64'hF);

        // Stall saturation then asynchronous reset mid-stall
        do_reset();
        step("sat.hs", 4'b0001, 0, 0, 1);
        step("sat.load", 4'b1110, 0, 0, 1);
        for (int i = 0; i < 20; i++) step("sat.hold", 4'b0000, 0, 0, 1);
        chk("sat.stall", 64'(stall_cnt), 64'(CMAX));
        #2;
        rst_n = 0;
        model_reset();
        #1;
        check_all("arst");
        chk("arst.v", 64'(out_valid), 64'd0);
        @(posedge clk); #3;
        rst_n = 1;
        @(posedge clk); #1;
        check_all("arst.rel");

        // Random traffic with occasional flush
        for (int i = 0; i < 400; i++)
            step("rand", N'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
